mc_ctrl_fsm: RTL and testbench



---
 rtl/mc_ctrl_pkg.sv | 60 ++++++
 rtl/mc_ctrl_out_dec.sv | 71 +++++++
 rtl/mc_ctrl_fsm.sv | 136 +++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle main control FSM.
// The optional MC_CTRL_PERF_EN build needs no extra package content.
`timescale 1ns/1ps
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC_R,
    EXEC_ADDI,
    EXEC_SUBI,
    I_WB,
    R_WB,
    MEM_ADDR,
    MEM_RD,
    MEM_WR,
    LW_WB,
    BRANCH
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_BEQ   = 2'b11;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  // States that own a memory access and may stall on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
  endfunction

endpackage

// File: rtl/mc_ctrl_out_dec.sv
// Moore decoder: current FSM state to datapath control word.
// FETCH completion strobes (ir_write/pc_write) are added by the FSM core.
`timescale 1ns/1ps
module mc_ctrl_out_dec
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
      end
      DECODE: begin
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      EXEC_ADDI, MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      EXEC_SUBI: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_SUB;
      end
      R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      I_WB: begin
        ctrl.reg_write = 1'b1;
      end
      MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      LW_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALUOP_BEQ;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset main control FSM with memory wait timeout.
// Define MC_CTRL_PERF_EN to add cycle_cnt/instr_cnt performance counters.
`timescale 1ns/1ps
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [1:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        pc_src,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal,
  output logic        timeout
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  ctrl_t      ctrl;
  logic       mem_wait;
  logic       wait_expired;
  logic       fetch_done;
  logic       unused;

  // zero only qualifies pc_write_cond inside the datapath's PC enable.
  assign unused = zero;

  assign mem_wait     = is_mem_state(state) && !mem_ready;
  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign fetch_done   = (state == FETCH) && mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      timeout  <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      illegal <= 1'b0;
      if (mem_wait) begin
        // A stalled access that exhausts its budget is dropped; restart at FETCH.
        if (wait_expired) begin
          timeout  <= 1'b1;
          state    <= FETCH;
          wait_cnt <= '0;
        end else begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end else begin
        wait_cnt <= '0;
        case (state)
          IDLE:   state <= FETCH;
          FETCH:  state <= DECODE;
          DECODE: begin
            case (opcode)
              OP_RTYPE:     state <= EXEC_R;
              OP_LW, OP_SW: state <= MEM_ADDR;
              OP_ADDI:      state <= EXEC_ADDI;
              OP_SUBI:      state <= EXEC_SUBI;
              OP_BEQ:       state <= BRANCH;
              default: begin
                state   <= FETCH;
                illegal <= 1'b1;
              end
            endcase
          end
          EXEC_R:              state <= R_WB;
          EXEC_ADDI, EXEC_SUBI: state <= I_WB;
          MEM_ADDR:            state <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
          MEM_RD:              state <= LW_WB;
          MEM_WR, R_WB, I_WB, LW_WB, BRANCH: state <= FETCH;
          default:             state <= IDLE;
        endcase
      end
    end
  end

  mc_ctrl_out_dec u_out_dec (
    .state (state),
    .ctrl  (ctrl)
  );

  assign alu_op        = ctrl.alu_op;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign pc_write      = ctrl.pc_write | fetch_done;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_src        = ctrl.pc_src;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write | fetch_done;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;

`ifdef MC_CTRL_PERF_EN
  logic instr_done;

  // An abandoned (timed-out) store does not retire.
  assign instr_done = (state == R_WB) || (state == I_WB) || (state == LW_WB) ||
                      (state == BRANCH) || ((state == MEM_WR) && mem_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != IDLE) cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done)    instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: the driver queues expected control words per
// cycle, a negedge monitor compares them. Build with MC_CTRL_PERF_EN for counters.
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write, pc_write_cond, pc_src, i_or_d;
  logic        mem_read, mem_write, ir_write;
  logic        reg_write, reg_dst, mem_to_reg;
  logic        illegal, timeout;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  always #5 clk = ~clk;

  mc_ctrl_fsm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .illegal       (illegal),
    .timeout       (timeout)
`ifdef MC_CTRL_PERF_EN
    ,
    .cycle_cnt     (cycle_cnt),
    .instr_cnt     (instr_cnt)
`endif
  );

  // Word layout: alu_op[2] src_a src_b[2] | pcw pwc pcsrc iord | mr mw irw rw | rd m2r ill to
  localparam logic [16:0] W_IDLE  = 17'b00_0_00_0000_0000_0000;
  localparam logic [16:0] W_FRDY  = 17'b00_0_01_1000_1010_0000;
  localparam logic [16:0] W_FWAIT = 17'b00_0_01_0000_1000_0000;
  localparam logic [16:0] W_DEC   = 17'b00_0_11_0000_0000_0000;
  localparam logic [16:0] W_EXR   = 17'b10_1_00_0000_0000_0000;
  localparam logic [16:0] W_ADDI  = 17'b00_1_10_0000_0000_0000;
  localparam logic [16:0] W_SUBI  = 17'b01_1_10_0000_0000_0000;
  localparam logic [16:0] W_RWB   = 17'b00_0_00_0000_0001_1000;
  localparam logic [16:0] W_IWB   = 17'b00_0_00_0000_0001_0000;
  localparam logic [16:0] W_MADDR = 17'b00_1_10_0000_0000_0000;
  localparam logic [16:0] W_MRD   = 17'b00_0_00_0001_1000_0000;
  localparam logic [16:0] W_MWR   = 17'b00_0_00_0001_0100_0000;
  localparam logic [16:0] W_LWWB  = 17'b00_0_00_0000_0001_0100;
  localparam logic [16:0] W_BR    = 17'b11_1_00_0110_0000_0000;
  localparam logic [16:0] B_ILL   = 17'b10;
  localparam logic [16:0] B_TO    = 17'b01;

  typedef struct {
    int          tag;
    int          kind;   // 0 control word, 1 perf counters {cycle_cnt, instr_cnt}
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   passed = 0;
  int   total = 0;
  logic [16:0] to_exp = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [16:0] act_word();
    return {alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond, pc_src, i_or_d,
            mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal, timeout};
  endfunction

  function automatic logic [63:0] act_perf();
`ifdef MC_CTRL_PERF_EN
    return {cycle_cnt, instr_cnt};
`else
    return 64'd0;
`endif
  endfunction

  // Monitor: compare every expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      exp_t e;
      logic [63:0] a;
      e = sb.pop_front();
      a = (e.kind == 1) ? act_perf() : {47'd0, act_word()};
      total++;
      if (e.tag != cyc)
        $display("FAIL %s: expectation for cycle %0d compared late at cycle %0d", e.name, e.tag, cyc);
      else if (a !== e.exp)
        $display("FAIL %s: got %b required %b", e.name, a[16:0], e.exp[16:0]);
      else begin
        passed++;
        $display("cyc %0d %-14s ok  word=%b", cyc, e.name, a[16:0]);
      end
    end
  end

  task automatic push(input string n, input int kind, input logic [63:0] w);
    exp_t e;
    e.tag = cyc; e.kind = kind; e.exp = w; e.name = n;
    sb.push_back(e);
  endtask

  task automatic step(input string n, input logic [16:0] w);
    push(n, 0, {47'd0, w | to_exp});
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'h00; zero = 1'b0;
    @(posedge clk); #1;
    step("in_reset", W_IDLE);
    rst_n = 1'b1;
    step("reset_idle", W_IDLE);

    // R-type, no stalls
    opcode = 6'h00; mem_ready = 1'b1;
    step("r_fetch", W_FRDY);
    step("r_decode", W_DEC);
    step("r_exec", W_EXR);
    step("r_wb", W_RWB);

    // lw with three MEM_RD stall cycles
    opcode = 6'h23;
    step("lw_fetch", W_FRDY);
    step("lw_decode", W_DEC);
    step("lw_addr", W_MADDR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("lw_rd_wait", W_MRD);
    mem_ready = 1'b1;
    step("lw_rd_done", W_MRD);
    step("lw_wb", W_LWWB);

    // beq taken and not taken: identical control
    opcode = 6'h04; zero = 1'b1;
    step("beq1_fetch", W_FRDY);
    step("beq1_decode", W_DEC);
    step("beq1_branch", W_BR);
    zero = 1'b0;
    step("beq0_fetch", W_FRDY);
    step("beq0_decode", W_DEC);
    step("beq0_branch", W_BR);

    opcode = 6'h0A;
    step("subi_fetch", W_FRDY);
    step("subi_decode", W_DEC);
    step("subi_exec", W_SUBI);
    step("subi_wb", W_IWB);

    opcode = 6'h08;
    step("addi_fetch", W_FRDY);
    step("addi_decode", W_DEC);
    step("addi_exec", W_ADDI);
    step("addi_wb", W_IWB);

    opcode = 6'h2B;
    step("sw_fetch", W_FRDY);
    step("sw_decode", W_DEC);
    step("sw_addr", W_MADDR);
    step("sw_wr", W_MWR);

    // Illegal opcode, then FETCH starved until timeout (15 wait cycles)
    opcode = 6'h3F;
    step("ill_fetch", W_FRDY);
    mem_ready = 1'b0;
    step("ill_decode", W_DEC);
    step("ill_pulse", W_FWAIT | B_ILL);
    for (int i = 0; i < 14; i++) step("fetch_wait", W_FWAIT);
    to_exp = B_TO;
    step("timeout_set", W_FWAIT);
    step("timeout_sticky", W_FWAIT);
    mem_ready = 1'b1;
    opcode = 6'h2B;
    step("to_fetch", W_FRDY);
    step("to_decode", W_DEC);
    step("to_addr", W_MADDR);
    mem_ready = 1'b0;
    step("to_wr_wait", W_MWR);

    // Asynchronous reset in MEM_WR: outputs drop before the next edge
    #1 rst_n = 1'b0;
    to_exp = '0;
    push("async_rst", 0, {47'd0, W_IDLE});
    @(posedge clk); #1;
    step("rst_held", W_IDLE);
    rst_n = 1'b1;
    step("rst_release", W_IDLE);

    // R, lw, sw, beq back to back: 4+5+4+3 = 16 cycles
    mem_ready = 1'b1;
    opcode = 6'h00;
    step("p_r_f", W_FRDY); step("p_r_d", W_DEC); step("p_r_x", W_EXR); step("p_r_wb", W_RWB);
    opcode = 6'h23;
    step("p_lw_f", W_FRDY); step("p_lw_d", W_DEC); step("p_lw_a", W_MADDR);
    step("p_lw_rd", W_MRD); step("p_lw_wb", W_LWWB);
    opcode = 6'h2B;
    step("p_sw_f", W_FRDY); step("p_sw_d", W_DEC); step("p_sw_a", W_MADDR); step("p_sw_wr", W_MWR);
    opcode = 6'h04;
    step("p_beq_f", W_FRDY); step("p_beq_d", W_DEC); step("p_beq_br", W_BR);
`ifdef MC_CTRL_PERF_EN
    push("perf_counts", 1, {32'd16, 32'd4});
`endif
    mem_ready = 1'b0;
    step("final_wait", W_FWAIT);

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
